// File: rtl/spi_reg_peripheral.sv
// SPI mode-0 write-only register target: 16-bit frames {wr, addr[6:0], data[7:0]} into five 8-bit registers.
// Latency: a register updates on the (SYNC_STAGES+1)th clk edge that samples ncs high at the end of a frame.
// No backpressure: the controller owns the pins; frames that cannot be committed are dropped and flagged on frame_err.
module spi_reg_peripheral #(
  parameter int MAX_ADDR    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       wr_strobe,
  output logic       frame_err
);

  // Synchroniser chains; shift in at bit 0, synced value at the top bit.
  logic [SYNC_STAGES-1:0] ncs_sync;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] copi_sync;
  logic                   ncs_hist;
  logic                   sclk_hist;

  logic        ncs_s;
  logic        sclk_s;
  logic        copi_s;
  logic        ncs_fall;
  logic        ncs_rise;
  logic        sclk_rise;
  logic        frame_ok;

  logic [15:0] shift_reg;
  logic [4:0]  bit_cnt;

  // Bring the SPI pins into the clk domain; reset values match the idle bus so no edge fires on release.
  always_ff @(posedge clk) begin
    if (rst) begin
      ncs_sync  <= '1;
      ncs_hist  <= 1'b1;
      sclk_sync <= '0;
      sclk_hist <= 1'b0;
      copi_sync <= '0;
    end else begin
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs};
      ncs_hist  <= ncs_sync[SYNC_STAGES-1];
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      sclk_hist <= sclk_sync[SYNC_STAGES-1];
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi};
    end
  end

  // Edge detection on the synchronised pins; copi shares the sclk pipeline depth so it is aligned with sclk_rise.
  always_comb begin
    ncs_s     = ncs_sync[SYNC_STAGES-1];
    sclk_s    = sclk_sync[SYNC_STAGES-1];
    copi_s    = copi_sync[SYNC_STAGES-1];
    ncs_fall  = ~ncs_s & ncs_hist;
    ncs_rise  = ncs_s & ~ncs_hist;
    sclk_rise = sclk_s & ~sclk_hist;
    frame_ok  = (bit_cnt == 5'd16) && shift_reg[15] && (shift_reg[14:8] <= 7'(MAX_ADDR));
  end

  // Frame capture: clear on frame start, shift MSB-first on sclk rising edges while selected; count saturates at 17.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (ncs_fall) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (sclk_rise && !ncs_s) begin
      shift_reg <= {shift_reg[14:0], copi_s};
      bit_cnt   <= (bit_cnt == 5'd17) ? 5'd17 : bit_cnt + 5'd1;
    end
  end

  // Commit at frame end: a well-formed write updates its register with the strobe on the same edge, anything else is flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_reg_out_7_0  <= 8'h00;
      en_reg_out_15_8 <= 8'h00;
      en_reg_pwm_7_0  <= 8'h00;
      en_reg_pwm_15_8 <= 8'h00;
      pwm_duty_cycle  <= 8'h00;
      wr_strobe       <= 1'b0;
      frame_err       <= 1'b0;
    end else begin
      wr_strobe <= ncs_rise & frame_ok;
      frame_err <= ncs_rise & ~frame_ok;
      if (ncs_rise && frame_ok) begin
        case (shift_reg[14:8])
          7'd0:    en_reg_out_7_0  <= shift_reg[7:0];
          7'd1:    en_reg_out_15_8 <= shift_reg[7:0];
          7'd2:    en_reg_pwm_7_0  <= shift_reg[7:0];
          7'd3:    en_reg_pwm_15_8 <= shift_reg[7:0];
          7'd4:    pwm_duty_cycle  <= shift_reg[7:0];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_peripheral.sv
// Bench for spi_reg_peripheral: drives SPI frames on the pins, predicts register contents and pulse counts.
// Latency: checks the commit edge precisely in the directed write and back-to-back scenarios.
// Backpressure: none; the bench paces SCLK at 4 clk per phase.
module tb_spi_reg_peripheral;

  logic       clk;
  logic       rst;
  logic       sclk;
  logic       copi;
  logic       ncs;
  logic [7:0] en_reg_out_7_0;
  logic [7:0] en_reg_out_15_8;
  logic [7:0] en_reg_pwm_7_0;
  logic [7:0] en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;
  logic       wr_strobe;
  logic       frame_err;

  int tests;
  int fails;
  int wr_seen;
  int err_seen;
  int exp_wr;
  int exp_err;
  logic [7:0] exp_regs [0:4];
  logic [39:0] dut_regs;

  localparam int PHASE = 4;

  spi_reg_peripheral #(.MAX_ADDR(4), .SYNC_STAGES(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .sclk            (sclk),
    .copi            (copi),
    .ncs             (ncs),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .wr_strobe       (wr_strobe),
    .frame_err       (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign dut_regs = {en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle};

  // Count high cycles of each pulse output and flag any overlap.
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_strobe === 1'b1) wr_seen++;
      if (frame_err === 1'b1) err_seen++;
      if (wr_strobe === 1'b1 || frame_err === 1'b1) begin
        tests++;
        if (wr_strobe === 1'b1 && frame_err === 1'b1) begin
          fails++;
          $display("FAIL strobe_overlap: wr_strobe=%b frame_err=%b, required not both high", wr_strobe, frame_err);
        end
      end
    end
  end

  function automatic logic [39:0] exp_vec();
    return {exp_regs[0], exp_regs[1], exp_regs[2], exp_regs[3], exp_regs[4]};
  endfunction

  // Reference: a frame is a committed write only if exactly 16 bits, write flag set, address in 0..4.
  task automatic model_frame(input logic [17:0] bits, input int n);
    logic [15:0] f;
    f = bits[15:0];
    if (n == 16 && f[15] && f[14:8] <= 7'd4) begin
      exp_regs[f[10:8]] = f[7:0];
      exp_wr++;
    end else begin
      exp_err++;
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_frame();
    ncs = 1'b0;
    wait_clk(PHASE);
  endtask

  task automatic send_bits(input logic [17:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      copi = bits[i];
      wait_clk(PHASE);
      sclk = 1'b1;
      wait_clk(PHASE);
      sclk = 1'b0;
    end
    wait_clk(PHASE);
  endtask

  task automatic end_frame();
    ncs = 1'b1;
    wait_clk(8);
  endtask

  task automatic send_frame(input logic [17:0] bits, input int n);
    start_frame();
    send_bits(bits, n);
    end_frame();
    model_frame(bits, n);
  endtask

  task automatic test_reset();
    rst = 1'b1; ncs = 1'b1; sclk = 1'b0; copi = 1'b0;
    wait_clk(2);
    tests++;
    if (dut_regs !== 40'h0) begin
      fails++; $display("FAIL reset_regs: got %h, required %h", dut_regs, 40'h0);
    end
    tests++;
    if (wr_strobe !== 1'b0 || frame_err !== 1'b0) begin
      fails++; $display("FAIL reset_pulses: wr_strobe=%b frame_err=%b, required 0 0", wr_strobe, frame_err);
    end
    rst = 1'b0;
    wait_clk(10);
    tests++;
    if (wr_seen !== 0 || err_seen !== 0) begin
      fails++; $display("FAIL reset_release_pulse: wr=%0d err=%0d, required 0 0", wr_seen, err_seen);
    end
  endtask

  task automatic test_valid_write();
    start_frame();
    send_bits(18'h08455, 16);
    ncs = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    tests++;
    if (pwm_duty_cycle !== 8'h00 || wr_strobe !== 1'b0) begin
      fails++; $display("FAIL write_early: duty=%h strobe=%b, required 00 0 after 2 edges", pwm_duty_cycle, wr_strobe);
    end
    @(posedge clk); #1;
    tests++;
    if (pwm_duty_cycle !== 8'h55 || wr_strobe !== 1'b1) begin
      fails++; $display("FAIL write_commit: duty=%h strobe=%b, required 55 1 on 3rd edge", pwm_duty_cycle, wr_strobe);
    end
    @(posedge clk); #1;
    tests++;
    if (wr_strobe !== 1'b0) begin
      fails++; $display("FAIL write_strobe_width: strobe=%b, required 0", wr_strobe);
    end
    wait_clk(6);
    model_frame(18'h08455, 16);
    tests++;
    if (dut_regs !== exp_vec()) begin
      fails++; $display("FAIL write_others: got %h, required %h", dut_regs, exp_vec());
    end
  endtask

  task automatic test_all_regs();
    logic [15:0] frames [0:4];
    int wr0;
    frames[0] = 16'h80F0; frames[1] = 16'h810F; frames[2] = 16'h82AA;
    frames[3] = 16'h8355; frames[4] = 16'h84FF;
    wr0 = wr_seen;
    for (int i = 0; i < 5; i++) send_frame({2'b00, frames[i]}, 16);
    tests++;
    if (dut_regs !== 40'hF00FAA55FF) begin
      fails++; $display("FAIL all_regs: got %h, required %h", dut_regs, 40'hF00FAA55FF);
    end
    tests++;
    if (wr_seen - wr0 !== 5) begin
      fails++; $display("FAIL all_regs_strobes: got %0d, required 5", wr_seen - wr0);
    end
  endtask

  task automatic test_rejects();
    logic [17:0] bits [0:4];
    int          lens [0:4];
    int          e0;
    int          w0;
    bits[0] = 18'h00233; lens[0] = 16;
    bits[1] = 18'h08533; lens[1] = 16;
    bits[2] = 18'h00411; lens[2] = 15;
    bits[3] = 18'h10223; lens[3] = 17;
    bits[4] = 18'h00000; lens[4] = 0;
    for (int i = 0; i < 5; i++) begin
      e0 = err_seen; w0 = wr_seen;
      send_frame(bits[i], lens[i]);
      tests++;
      if (dut_regs !== exp_vec()) begin
        fails++; $display("FAIL reject%0d_regs: got %h, required %h", i, dut_regs, exp_vec());
      end
      tests++;
      if (err_seen - e0 !== 1 || wr_seen - w0 !== 0) begin
        fails++; $display("FAIL reject%0d_pulses: err=%0d wr=%0d, required 1 0", i, err_seen - e0, wr_seen - w0);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int e0;
    start_frame();
    send_bits(18'h00080, 8);
    rst = 1'b1;
    wait_clk(1);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) exp_regs[i] = 8'h00;
    wait_clk(PHASE);
    e0 = err_seen;
    send_bits(18'h00099, 8);
    end_frame();
    exp_err++;
    tests++;
    if (en_reg_out_7_0 !== 8'h00 || dut_regs !== exp_vec()) begin
      fails++; $display("FAIL midreset_regs: got %h, required %h", dut_regs, exp_vec());
    end
    tests++;
    if (err_seen - e0 !== 1) begin
      fails++; $display("FAIL midreset_err: got %0d pulses, required 1", err_seen - e0);
    end
  endtask

  task automatic test_back_to_back();
    int e0;
    int w0;
    e0 = err_seen; w0 = wr_seen;
    start_frame();
    send_bits(18'h08011, 16);
    ncs = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (en_reg_out_7_0 !== 8'h11) begin
      fails++; $display("FAIL b2b_first: got %h, required 11", en_reg_out_7_0);
    end
    @(negedge clk);
    ncs = 1'b0;
    wait_clk(PHASE);
    send_bits(18'h08022, 16);
    end_frame();
    model_frame(18'h08011, 16);
    model_frame(18'h08022, 16);
    tests++;
    if (en_reg_out_7_0 !== 8'h22 || dut_regs !== exp_vec()) begin
      fails++; $display("FAIL b2b_second: got %h, required %h", dut_regs, exp_vec());
    end
    tests++;
    if (wr_seen - w0 !== 2 || err_seen - e0 !== 0) begin
      fails++; $display("FAIL b2b_pulses: wr=%0d err=%0d, required 2 0", wr_seen - w0, err_seen - e0);
    end
  endtask

  task automatic test_random();
    logic [17:0] bits;
    int          n;
    int          r;
    for (int k = 0; k < 20; k++) begin
      r = $urandom_range(0, 9);
      n = (r < 7) ? 16 : ((r == 7) ? 15 : 17);
      bits = 18'($urandom);
      bits[15]   = ($urandom_range(0, 3) != 0);
      bits[14:8] = 7'($urandom_range(0, 6));
      send_frame(bits, n);
      tests++;
      if (dut_regs !== exp_vec()) begin
        fails++; $display("FAIL random%0d_regs: frame=%h len=%0d got %h, required %h", k, bits, n, dut_regs, exp_vec());
      end
    end
    tests++;
    if (wr_seen !== exp_wr || err_seen !== exp_err) begin
      fails++; $display("FAIL total_pulses: wr=%0d err=%0d, required %0d %0d", wr_seen, err_seen, exp_wr, exp_err);
    end
  endtask

  initial begin
    tests = 0; fails = 0; wr_seen = 0; err_seen = 0; exp_wr = 0; exp_err = 0;
    for (int i = 0; i < 5; i++) exp_regs[i] = 8'h00;
    rst = 1'b1; ncs = 1'b1; sclk = 1'b0; copi = 1'b0;
    test_reset();
    test_valid_write();
    test_all_regs();
    test_rejects();
    test_reset_mid_frame();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_reg_peripheral.md
Name: spi_reg_peripheral

Overview:
- SPI mode-0 target that decodes 16-bit write frames from the external controller.
- Drives the configuration registers consumed by the downstream PWM/output-enable stage inside tt_um_uwasic_onboarding_parasinder_m.
- Sits directly upstream of the PWM peripheral; the tt_um top connects sclk/copi/ncs from ui_in[0..2].
- SPI pins are asynchronous to clk; all frame decoding happens in the clk domain after synchronisation.

Parameters:
- MAX_ADDR, 4, highest valid register address; writes to higher addresses are discarded.
- SYNC_STAGES, 2, synchroniser flops per SPI input, before the edge-detect flop.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- sclk  input  1  SPI clock, asynchronous
- copi  input  1  SPI data in, MSB first, asynchronous
- ncs  input  1  SPI chip select, active low, asynchronous
- en_reg_out_7_0  output  8  register 0x00
- en_reg_out_15_8  output  8  register 0x01
- en_reg_pwm_7_0  output  8  register 0x02
- en_reg_pwm_15_8  output  8  register 0x03
- pwm_duty_cycle  output  8  register 0x04
- wr_strobe  output  1  one-cycle pulse on each committed write
- frame_err  output  1  one-cycle pulse on each discarded frame

Behaviour:
- Reset (rst=1 at a clk edge):
  - All five registers = 0x00; wr_strobe = 0; frame_err = 0.
  - Shift register = 0; bit counter = 0.
  - Synchroniser and edge flops: ncs chain = 1, sclk chain = 0, copi chain = 0. No false edge is produced on release.
- Synchronisation: each input passes through SYNC_STAGES flops plus one history flop. Edges are detected as synced & ~history.
- Timing constraint: SCLK high and low phases each ≥ 3 clk periods. No overclock detection is required.
- Frame start: synced ncs falling edge clears the shift register and the 5-bit bit counter.
- Bit capture: on a synced sclk rising edge while synced ncs = 0:
  - shift_reg <= {shift_reg[14:0], synced copi}.
  - Counter increments and saturates at 17.
  - SCLK falling edges are ignored.
- Frame fields: bit15 = R/W (1 = write), bits14:8 = address, bits7:0 = data.
- Frame end: on the clk edge following detection of a synced ncs rising edge:
  - If count == 16, bit15 == 1 and address ≤ MAX_ADDR: write data to the addressed register and pulse wr_strobe for exactly 1 cycle. The register value and the strobe are visible from the same edge.
  - Otherwise: no register changes and frame_err pulses for 1 cycle. This covers short frames, frames longer than 16 bits, reads (bit15 = 0) and bad addresses.
- Commit latency: with SYNC_STAGES = 2, the register updates on the 3rd rising clk edge at which the ncs pin is sampled high.
- Read frames are accepted and discarded. No CIPO output exists.
- Registers hold their value indefinitely between frames. Only reset or a valid write changes them.
- SCLK edges while ncs = 1 are ignored. The counter is not touched.
- ncs glitch (low then high with 0 SCLK edges): counts as a frame with count 0, so frame_err pulses and no write occurs.
- Reset mid-frame:
  - The frame in flight is lost. Counter restarts at 0.
  - Bits arriving after rst deasserts are counted, so the frame normally ends with count ≠ 16 and is discarded.
  - rst takes priority over a same-cycle commit.
- Back-to-back frames: a new ncs falling edge may occur ≥ 3 clk after the previous rising edge. The commit of the previous frame must not be lost.
- wr_strobe and frame_err are never high in the same cycle.

Test Plan:
- Reset: assert rst 2 cycles with ncs = 1 → all registers 0x00, wr_strobe = 0, frame_err = 0, no pulse after release.
- Valid write: frame 0x8455 (write, addr 0x04, data 0x55) → pwm_duty_cycle = 0x55 on the 3rd clk edge after ncs high, one wr_strobe pulse, other registers remain 0x00.
- All registers: frames 0x80F0, 0x810F, 0x82AA, 0x8355, 0x84FF → en_reg_out_7_0 = 0xF0, en_reg_out_15_8 = 0x0F, en_reg_pwm_7_0 = 0xAA, en_reg_pwm_15_8 = 0x55, pwm_duty_cycle = 0xFF; 5 wr_strobe pulses.
- Rejects, each → registers unchanged and one frame_err pulse:
  - read frame 0x0233
  - bad-address frame 0x8533
  - 15-bit frame
  - 17-bit frame
- Reset mid-frame: after 8 bits of 0x8099, pulse rst for 1 cycle, send the remaining 8 bits → en_reg_out_7_0 = 0x00 and frame_err pulses.
- Back-to-back: 0x8011 then 0x8022 with 3 clk between ncs rise and fall → en_reg_out_7_0 reads 0x11 then 0x22; 2 wr_strobe pulses, 0 frame_err.
